fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipeline. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents `{if_valid, if_pc, if_instr}` to the IF/ID pipeline register (`ff` instances enabled by `!stall`). It handles downstream back-pressure with a one-entry skid buffer, and handles branch/exception redirects, including redirects that arrive while a memory read is outstanding.

## Interface
- `BITS`, 32, width of PC, address and instruction.
- `START_PC`, 32'h0000_1000, PC loaded at reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `stall`  in  1  IF/ID register not accepting this cycle.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  BITS  redirect target; bits [1:0] treated as 0.
- `mem_req`  out  1  read request valid.
- `mem_addr`  out  BITS  read address; stable while `mem_req`=1 until ack.
- `mem_ack`  in  1  read data valid this cycle; only meaningful when `mem_req`=1.
- `mem_rdata`  in  BITS  instruction word, valid with `mem_ack`.
- `if_valid`  out  1  registered; output slot holds an instruction.
- `if_pc`  out  BITS  registered; PC of `if_instr`.
- `if_instr`  out  BITS  registered instruction word.

## Operation
- Registers: `pc` (next address to request), `req_pc` (address of outstanding request, drives `mem_addr`), skid `{sk_pc, sk_instr}`, output regs, 2-bit state.
- Reset (async, while `reset`=0): state BUSY, `pc`=`START_PC`+4, `req_pc`=`START_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0, skid=0. `mem_req` is forced to 0 while reset is low.
- Slot free = `!if_valid || !stall`.
- `mem_req`=1 in BUSY and DRAIN, 0 in HOLD. A request, once raised, is never withdrawn before `mem_ack`.
- BUSY:
  - `redirect` && `mem_ack`: discard data; `req_pc`←target, `pc`←target+4, `if_valid`←0; stay BUSY.
  - `redirect` && !`mem_ack`: `pc`←target, `if_valid`←0; go to DRAIN.
  - `mem_ack` && slot free: outputs←{1, `req_pc`, `mem_rdata`}; `req_pc`←`pc`, `pc`←`pc`+4; stay BUSY.
  - `mem_ack` && slot not free: skid←{`req_pc`, `mem_rdata`}; `req_pc`←`pc`, `pc`←`pc`+4; go to HOLD.
  - No ack && !`stall`: `if_valid`←0 (bubble).
- HOLD:
  - `redirect`: drop skid; `req_pc`←target, `pc`←target+4, `if_valid`←0; go to BUSY.
  - Else if !`stall`: outputs←{1, skid}; go to BUSY.
  - Else: hold everything.
- DRAIN:
  - `mem_ack`: discard data; `req_pc`←`pc`, `pc`←`pc`+4; go to BUSY.
  - `redirect` (with or without ack): `pc`←newest target; a later redirect overrides an earlier one.
  - `if_valid` stays 0.
- `redirect` has priority over stall, ack and skid. It always clears `if_valid` at the next edge.
- Arithmetic: `pc`+4 is modulo 2^BITS; 0xFFFF_FFFC+4 = 0.

## Timing
- Fetch latency: `if_valid` rises on the edge that samples `mem_ack`. With ack in the same cycle as req, throughput is 1 instr/cycle.
- First `mem_req` is high in the first cycle after `reset` deasserts, with `mem_addr`=`START_PC`.
- Redirect-to-request: the next cycle's `mem_addr`=target, except in DRAIN, where it waits for the old ack.
- Outputs are stable whenever `if_valid && stall`.
- Skid release: on the first `!stall` edge in HOLD, outputs take the skid entry; `mem_req` is high the following cycle.
- Reset mid-operation: all outputs are reset values immediately (asynchronous). The outstanding memory transaction is abandoned; memory shares the reset.
- Never two states asserting `mem_req` with different `mem_addr` before an ack.

## Test plan
- Reset release, `START_PC`=0x1000, `mem_ack` tied 1, `mem_rdata`=`mem_addr`^0xA5A5A5A5 -> `if_valid`=1 from first edge; `if_pc` 0x1000, 0x1004, 0x1008 on consecutive cycles with matching `if_instr`.
- Streaming, `stall`=1 for 3 cycles while `if_pc`=0x1004 -> outputs hold 0x1004; one ack fills skid (0x1008); `mem_req`=0 in HOLD; on release `if_pc` 0x1008 then 0x100C; no loss or duplicate.
- `redirect`=1 with `redirect_pc`=0x2000 in the same cycle as an ack for 0x1008 -> next cycle `if_valid`=0, `mem_addr`=0x2000; then `if_pc`=0x2000.
- `mem_ack` delayed 3 cycles, `redirect` to 0x3000 in cycle 1, then again to 0x4000 in cycle 2 -> `mem_addr` holds old address until ack; data dropped; next `mem_addr`=0x4000; no 0x3000 fetch.
- `reset`=0 asserted mid-DRAIN -> `if_valid`=0, `mem_req`=0 immediately; after release, first `mem_addr`=0x1000.
- Redirect to 0xFFFF_FFFC with ack tied 1 -> `if_pc` 0xFFFF_FFFC, then 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program counter, issues word reads to
// instruction memory over a req/ack handshake and presents
// {if_valid, if_pc, if_instr} to the IF/ID pipeline register. Downstream
// back-pressure is absorbed by a one-entry skid buffer. Branch/exception
// redirects are honoured immediately, or after the outstanding read returns
// when one is in flight (DRAIN).
//
// Ports
//   clk          in   1     rising-edge clock
//   reset        in   1     asynchronous, active-low reset (0 = in reset)
//   stall        in   1     IF/ID register not accepting this cycle
//   redirect     in   1     flush and restart fetch at redirect_pc
//   redirect_pc  in   BITS  redirect target, bits [1:0] ignored
//   mem_req      out  1     read request valid (forced 0 while in reset)
//   mem_addr     out  BITS  read address, stable until mem_ack
//   mem_ack      in   1     read data valid this cycle
//   mem_rdata    in   BITS  instruction word, valid with mem_ack
//   if_valid     out  1     output slot holds an instruction
//   if_pc        out  BITS  PC of if_instr
//   if_instr     out  BITS  instruction word
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int          BITS     = 32,
    parameter logic [31:0] START_PC = 32'h0000_1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [BITS-1:0] redirect_pc,
    output logic            mem_req,
    output logic [BITS-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [BITS-1:0] mem_rdata,
    output logic            if_valid,
    output logic [BITS-1:0] if_pc,
    output logic [BITS-1:0] if_instr
);

    // BUSY : request outstanding, data goes to output slot or skid
    // HOLD : skid full, no request until the slot drains
    // DRAIN: redirected while a read is in flight; wait for and drop its data
    localparam logic [1:0] ST_BUSY  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [BITS-1:0] PC_STEP    = {{(BITS-3){1'b0}}, 3'b100};
    localparam logic [BITS-1:0] ALIGN_MASK = ~{{(BITS-2){1'b0}}, 2'b11};
    localparam logic [BITS-1:0] ZERO_W     = {BITS{1'b0}};
    localparam logic [BITS-1:0] START_W    = START_PC[BITS-1:0];

    logic [1:0]      state_q,    state_d;
    logic [BITS-1:0] pc_q,       pc_d;
    logic [BITS-1:0] req_pc_q,   req_pc_d;
    logic [BITS-1:0] sk_pc_q,    sk_pc_d;
    logic [BITS-1:0] sk_instr_q, sk_instr_d;
    logic            if_valid_q, if_valid_d;
    logic [BITS-1:0] if_pc_q,    if_pc_d;
    logic [BITS-1:0] if_instr_q, if_instr_d;

    logic [BITS-1:0] tgt_s;
    logic [BITS-1:0] tgt_next_s;
    logic [BITS-1:0] pc_next_s;
    logic            slot_free_s;

    assign tgt_s       = redirect_pc & ALIGN_MASK;
    assign tgt_next_s  = tgt_s + PC_STEP;
    assign pc_next_s   = pc_q + PC_STEP;
    assign slot_free_s = !if_valid_q || !stall;

    // State and datapath registers, asynchronously cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BUSY;
            pc_q       <= START_W + PC_STEP;
            req_pc_q   <= START_W;
            sk_pc_q    <= ZERO_W;
            sk_instr_q <= ZERO_W;
            if_valid_q <= 1'b0;
            if_pc_q    <= ZERO_W;
            if_instr_q <= ZERO_W;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            sk_pc_q    <= sk_pc_d;
            sk_instr_q <= sk_instr_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Next-state and datapath update; redirect outranks stall, ack and skid
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        sk_pc_d    = sk_pc_q;
        sk_instr_d = sk_instr_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;

        case (state_q)
            ST_BUSY: begin
                if (redirect) begin
                    if_valid_d = 1'b0;
                    if (mem_ack) begin
                        // Old data is discarded; the new request goes out next cycle
                        req_pc_d = tgt_s;
                        pc_d     = tgt_next_s;
                    end else begin
                        // Request cannot be withdrawn: remember target, wait for ack
                        pc_d    = tgt_s;
                        state_d = ST_DRAIN;
                    end
                end else if (mem_ack) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_next_s;
                    if (slot_free_s) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = req_pc_q;
                        if_instr_d = mem_rdata;
                    end else begin
                        sk_pc_d    = req_pc_q;
                        sk_instr_d = mem_rdata;
                        state_d    = ST_HOLD;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end else begin
                    if_valid_d = if_valid_q;
                end
            end

            ST_HOLD: begin
                if (redirect) begin
                    sk_pc_d    = ZERO_W;
                    sk_instr_d = ZERO_W;
                    req_pc_d   = tgt_s;
                    pc_d       = tgt_next_s;
                    if_valid_d = 1'b0;
                    state_d    = ST_BUSY;
                end else if (!stall) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = sk_pc_q;
                    if_instr_d = sk_instr_q;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                if_valid_d = 1'b0;
                if (mem_ack) begin
                    // Stale data dropped; fetch the newest target next
                    req_pc_d = redirect ? tgt_s : pc_q;
                    pc_d     = redirect ? tgt_next_s : pc_next_s;
                    state_d  = ST_BUSY;
                end else if (redirect) begin
                    pc_d = tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean fetch at the current request
                if_valid_d = 1'b0;
                state_d    = ST_BUSY;
            end
        endcase
    end

    // Output decode; mem_req is gated by reset so it drops asynchronously
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = req_pc_q;
        case (state_q)
            ST_BUSY:  mem_req = reset;
            ST_DRAIN: mem_req = reset;
            ST_HOLD:  mem_req = 1'b0;
            default:  mem_req = 1'b0;
        endcase
    end

    assign if_valid = if_valid_q;
    assign if_pc    = if_pc_q;
    assign if_instr = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed self-checking bench for fetch_unit. The memory model returns
// mem_addr ^ 32'hA5A5A5A5 as instruction data; all expected values below are
// hand-derived from that rule and START_PC = 0x1000.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] XK = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_errors = 0;

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Instruction memory model: data is a fixed function of the address
    assign mem_rdata = mem_addr ^ XK;

    fetch_unit #(
        .BITS     (32),
        .START_PC (32'h0000_1000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expect a valid instruction at the output slot
    task automatic check_out(input string tag, input logic [31:0] pc);
        check_eq({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        check_eq({tag, ".pc"},    if_pc,             pc);
        check_eq({tag, ".instr"}, if_instr,          pc ^ XK);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        mem_ack     = 1'b1;

        // ---- Reset state ----
        #1;
        check_eq("rst.valid", {31'd0, if_valid}, 32'd0);
        check_eq("rst.req",   {31'd0, mem_req},  32'd0);
        check_eq("rst.pc",    if_pc,             32'd0);
        check_eq("rst.instr", if_instr,          32'd0);

        // ---- Release and stream with ack tied high ----
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel.req",  {31'd0, mem_req}, 32'd1);
        check_eq("rel.addr", mem_addr,         32'h0000_1000);
        step();
        check_out("s0", 32'h0000_1000);
        step();
        check_out("s1", 32'h0000_1004);

        // ---- Stall 3 cycles while 0x1004 is presented ----
        stall = 1'b1;
        step();
        check_out("st0", 32'h0000_1004);
        check_eq("st0.req", {31'd0, mem_req}, 32'd0);
        step();
        check_out("st1", 32'h0000_1004);
        check_eq("st1.req", {31'd0, mem_req}, 32'd0);
        step();
        check_out("st2", 32'h0000_1004);
        stall = 1'b0;
        step();
        check_out("skid", 32'h0000_1008);
        check_eq("skid.req",  {31'd0, mem_req}, 32'd1);
        check_eq("skid.addr", mem_addr,         32'h0000_100C);
        step();
        check_out("post", 32'h0000_100C);
        check_eq("post.addr", mem_addr, 32'h0000_1010);

        // ---- Redirect coincident with an ack ----
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        step();
        redirect = 1'b0;
        check_eq("rda.valid", {31'd0, if_valid}, 32'd0);
        check_eq("rda.addr",  mem_addr,          32'h0000_2000);
        step();
        check_out("rda.out", 32'h0000_2000);
        check_eq("rda.next", mem_addr, 32'h0000_2004);

        // ---- Two redirects while the read of 0x2004 is outstanding ----
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        step();
        check_eq("dr1.valid", {31'd0, if_valid}, 32'd0);
        check_eq("dr1.req",   {31'd0, mem_req},  32'd1);
        check_eq("dr1.addr",  mem_addr,          32'h0000_2004);
        redirect_pc = 32'h0000_4000;
        step();
        redirect = 1'b0;
        check_eq("dr2.addr", mem_addr, 32'h0000_2004);
        step();
        check_eq("dr3.addr",  mem_addr,          32'h0000_2004);
        check_eq("dr3.valid", {31'd0, if_valid}, 32'd0);
        mem_ack = 1'b1;
        step();
        check_eq("dr4.valid", {31'd0, if_valid}, 32'd0);
        check_eq("dr4.addr",  mem_addr,          32'h0000_4000);
        step();
        check_out("dr5", 32'h0000_4000);

        // ---- Asynchronous reset while in DRAIN ----
        mem_ack     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_5000;
        step();
        redirect = 1'b0;
        check_eq("pre.req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("ar.valid", {31'd0, if_valid}, 32'd0);
        check_eq("ar.req",   {31'd0, mem_req},  32'd0);
        check_eq("ar.pc",    if_pc,             32'd0);
        check_eq("ar.addr",  mem_addr,          32'h0000_1000);
        @(negedge clk);
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check_eq("ar2.req",  {31'd0, mem_req}, 32'd1);
        check_eq("ar2.addr", mem_addr,         32'h0000_1000);
        step();
        check_out("ar2.out", 32'h0000_1000);

        // ---- Wrap-around at the top of the address space, low bits masked ----
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect = 1'b0;
        check_eq("wr.valid", {31'd0, if_valid}, 32'd0);
        check_eq("wr.addr",  mem_addr,          32'hFFFF_FFFC);
        step();
        check_out("wr0", 32'hFFFF_FFFC);
        step();
        check_out("wr1", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
